// File: rtl/fifo_counted.sv
// fifo_counted: counted ready/valid/yumi FIFO with flush and almost-full/almost-empty flags, any depth >= 2.
// Define FIFO_COUNTED_ERR_EN to add the sticky err_o overrun/underrun flags.
module fifo_counted #(
  parameter int width_p        = 8,
  parameter int depth_p        = 128,
  parameter int almost_full_p  = depth_p - 2,
  parameter int almost_empty_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o
`ifdef FIFO_COUNTED_ERR_EN
  ,
  output logic [1:0]                   err_o
`endif
);

  localparam int ptr_w_lp = (depth_p > 2) ? $clog2(depth_p) : 1;
  localparam int cnt_w_lp = $clog2(depth_p + 1);

  localparam logic [ptr_w_lp-1:0] last_ptr_lp  = ptr_w_lp'(depth_p - 1);
  localparam logic [cnt_w_lp-1:0] depth_cnt_lp = cnt_w_lp'(depth_p);
  localparam logic [cnt_w_lp-1:0] af_cnt_lp    = cnt_w_lp'(almost_full_p);
  localparam logic [cnt_w_lp-1:0] ae_cnt_lp    = cnt_w_lp'(almost_empty_p);

  if (depth_p < 2) begin : g_bad_depth
    $error("fifo_counted: depth_p (%0d) must be >= 2", depth_p);
  end
  if ((almost_full_p < 1) || (almost_full_p > depth_p)) begin : g_bad_af
    $error("fifo_counted: almost_full_p (%0d) must be in 1..depth_p", almost_full_p);
  end
  if ((almost_empty_p < 0) || (almost_empty_p >= depth_p)) begin : g_bad_ae
    $error("fifo_counted: almost_empty_p (%0d) must be in 0..depth_p-1", almost_empty_p);
  end

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == last_ptr_lp) begin
      return {ptr_w_lp{1'b0}};
    end else begin
      return p + ptr_w_lp'(1);
    end
  endfunction

  logic [width_p-1:0]  mem [depth_p];
  logic [ptr_w_lp-1:0] rd_ptr;
  logic [ptr_w_lp-1:0] wr_ptr;
  logic [cnt_w_lp-1:0] count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full  = (count == depth_cnt_lp);
  assign empty = (count == {cnt_w_lp{1'b0}});
  assign push  = valid_i & ~full;
  assign pop   = yumi_i & ~empty;

  assign ready_o        = ~full;
  assign valid_o        = ~empty;
  assign data_o         = mem[rd_ptr];
  assign count_o        = count;
  assign almost_full_o  = (count >= af_cnt_lp);
  assign almost_empty_o = (count <= ae_cnt_lp);

  // Storage is not reset; a flushed push is never written.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr <= {ptr_w_lp{1'b0}};
      wr_ptr <= {ptr_w_lp{1'b0}};
      count  <= {cnt_w_lp{1'b0}};
    end else if (flush_i) begin
      rd_ptr <= {ptr_w_lp{1'b0}};
      wr_ptr <= {ptr_w_lp{1'b0}};
      count  <= {cnt_w_lp{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + cnt_w_lp'(1);
        2'b01:   count <= count - cnt_w_lp'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_COUNTED_ERR_EN
  logic [1:0] err;

  // Sticky record of overrun attempts (bit0) and yumi-while-empty (bit1).
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err <= 2'b00;
    end else if (flush_i) begin
      err <= 2'b00;
    end else begin
      err <= err | {yumi_i & empty, valid_i & full};
    end
  end

  assign err_o = err;

`ifndef SYNTHESIS
  // Simulation-only notice for each protocol event.
  always @(posedge clk_i) begin
    if (reset_ni && valid_i && full) begin
      $warning("fifo_counted: valid_i while full (overrun attempt)");
    end
    if (reset_ni && yumi_i && empty) begin
      $warning("fifo_counted: yumi_i while empty (protocol violation)");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_fifo_counted.sv
// Directed self-checking bench for fifo_counted: a depth-5 instance (wrap/concurrency)
// and a depth-8 instance (flags/flush), with err_o checks when FIFO_COUNTED_ERR_EN is defined.
module tb_fifo_counted;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_ni;
  logic       f5, v5, y5, r5, vo5, af5, ae5;
  logic [7:0] d5, q5;
  logic [2:0] c5;
  logic       f8, v8, y8, r8, vo8, af8, ae8;
  logic [7:0] d8, q8;
  logic [3:0] c8;
`ifdef FIFO_COUNTED_ERR_EN
  logic [1:0] e5, e8;
`endif

  int errors = 0;
  int checks = 0;

  fifo_counted #(.width_p(8), .depth_p(5)) dut5 (
    .clk_i(clk), .reset_ni(reset_ni), .flush_i(f5), .valid_i(v5), .data_i(d5),
    .ready_o(r5), .valid_o(vo5), .data_o(q5), .yumi_i(y5), .count_o(c5),
    .almost_full_o(af5), .almost_empty_o(ae5)
`ifdef FIFO_COUNTED_ERR_EN
    , .err_o(e5)
`endif
  );

  fifo_counted #(.width_p(8), .depth_p(8), .almost_full_p(6), .almost_empty_p(2)) dut8 (
    .clk_i(clk), .reset_ni(reset_ni), .flush_i(f8), .valid_i(v8), .data_i(d8),
    .ready_o(r8), .valid_o(vo8), .data_o(q8), .yumi_i(y8), .count_o(c8),
    .almost_full_o(af8), .almost_empty_o(ae8)
`ifdef FIFO_COUNTED_ERR_EN
    , .err_o(e8)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    #2;
    checks++; if (r5 !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b want 1", r5); end
    checks++; if (vo5 !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", vo5); end
    checks++; if (c5 !== 3'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", c5); end
    checks++; if (af5 !== 1'b0)  begin errors++; $display("FAIL reset_af: got %b want 0", af5); end
    checks++; if (ae5 !== 1'b1)  begin errors++; $display("FAIL reset_ae: got %b want 1", ae5); end
    reset_ni = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      v5 = 1'b1; d5 = 8'hA1 + 8'(i);
      tick();
    end
    v5 = 1'b0;
    checks++; if (c5 !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d want 3", c5); end
    reset_ni = 1'b0;
    #1;  // no clock edge between assertion and check
    checks++; if (c5 !== 3'd0)  begin errors++; $display("FAIL async_reset_count: got %0d want 0", c5); end
    checks++; if (vo5 !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", vo5); end
    checks++; if (r5 !== 1'b1)  begin errors++; $display("FAIL async_reset_ready: got %b want 1", r5); end
    checks++; if (ae5 !== 1'b1) begin errors++; $display("FAIL async_reset_ae: got %b want 1", ae5); end
    tick();
    reset_ni = 1'b1;
    tick();
    checks++; if (c5 !== 3'd0 || vo5 !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: count %0d valid %b want 0/0", c5, vo5);
    end
  endtask

  task automatic fill5_from_11;
    for (int i = 0; i < 5; i++) begin
      v5 = 1'b1; d5 = 8'h11 + 8'(i);
      tick();
      checks++; if (c5 !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", c5, i + 1); end
    end
    v5 = 1'b0;
  endtask

  task automatic test_fill_wrap;
    fill5_from_11();
    checks++; if (r5 !== 1'b0)  begin errors++; $display("FAIL full_ready: got %b want 0", r5); end
    checks++; if (af5 !== 1'b1) begin errors++; $display("FAIL full_af: got %b want 1", af5); end
    for (int k = 0; k < 7; k++) begin
      checks++; if (q5 !== 8'h11 + 8'(k)) begin
        errors++; $display("FAIL wrap_pop_data: got %h want %h", q5, 8'h11 + 8'(k));
      end
      y5 = 1'b1;
      tick();
      y5 = 1'b0;
      checks++; if (c5 !== 3'd4) begin errors++; $display("FAIL wrap_pop_count: got %0d want 4", c5); end
      v5 = 1'b1; d5 = 8'h16 + 8'(k);
      tick();
      v5 = 1'b0;
      checks++; if (c5 !== 3'd5) begin errors++; $display("FAIL wrap_push_count: got %0d want 5", c5); end
    end
    checks++; if (q5 !== 8'h18) begin errors++; $display("FAIL wrap_head: got %h want 18", q5); end
  endtask

  task automatic test_full_concurrency;
    f5 = 1'b1;
    tick();
    f5 = 1'b0;
    checks++; if (c5 !== 3'd0) begin errors++; $display("FAIL flush5_count: got %0d want 0", c5); end
    fill5_from_11();
    v5 = 1'b1; d5 = 8'hEE; y5 = 1'b1;
    tick();
    v5 = 1'b0; y5 = 1'b0;
    checks++; if (c5 !== 3'd4) begin errors++; $display("FAIL full_conc_count: got %0d want 4", c5); end
    checks++; if (r5 !== 1'b1) begin errors++; $display("FAIL full_conc_ready: got %b want 1", r5); end
    v5 = 1'b1; d5 = 8'h99;
    tick();
    v5 = 1'b0;
    checks++; if (c5 !== 3'd5) begin errors++; $display("FAIL full_conc_next_push: got %0d want 5", c5); end
    for (int k = 0; k < 5; k++) begin
      logic [7:0] exp;
      exp = (k < 4) ? 8'h12 + 8'(k) : 8'h99;
      checks++; if (q5 !== exp) begin errors++; $display("FAIL full_conc_drain: got %h want %h", q5, exp); end
      y5 = 1'b1;
      tick();
    end
    y5 = 1'b0;
    checks++; if (vo5 !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b want 0", vo5); end
  endtask

  task automatic test_empty_concurrency;
    v5 = 1'b1; d5 = 8'hA5; y5 = 1'b1;
    tick();
    v5 = 1'b0; y5 = 1'b0;
    checks++; if (c5 !== 3'd1)   begin errors++; $display("FAIL empty_conc_count: got %0d want 1", c5); end
    checks++; if (vo5 !== 1'b1)  begin errors++; $display("FAIL empty_conc_valid: got %b want 1", vo5); end
    checks++; if (q5 !== 8'hA5)  begin errors++; $display("FAIL empty_conc_data: got %h want a5", q5); end
  endtask

  task automatic test_flags;
    for (int n = 1; n <= 8; n++) begin
      v8 = 1'b1; d8 = 8'h40 + 8'(n);
      tick();
      checks++; if (c8 !== 4'(n))     begin errors++; $display("FAIL flag_fill_count: got %0d want %0d", c8, n); end
      checks++; if (af8 !== (n >= 6)) begin errors++; $display("FAIL flag_fill_af at %0d: got %b", n, af8); end
      checks++; if (ae8 !== (n <= 2)) begin errors++; $display("FAIL flag_fill_ae at %0d: got %b", n, ae8); end
    end
    v8 = 1'b0;
    checks++; if (r8 !== 1'b0) begin errors++; $display("FAIL flag_full_ready: got %b want 0", r8); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (q8 !== 8'h41 + 8'(k)) begin errors++; $display("FAIL flag_pop_data: got %h want %h", q8, 8'h41 + 8'(k)); end
      y8 = 1'b1;
      tick();
      checks++; if (af8 !== (7 - k >= 6)) begin errors++; $display("FAIL flag_pop_af at %0d: got %b", 7 - k, af8); end
      checks++; if (ae8 !== (7 - k <= 2)) begin errors++; $display("FAIL flag_pop_ae at %0d: got %b", 7 - k, ae8); end
    end
    y8 = 1'b0;
    checks++; if (c8 !== 4'd0) begin errors++; $display("FAIL flag_end_count: got %0d want 0", c8); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 4; i++) begin
      v8 = 1'b1; d8 = 8'h60 + 8'(i);
      tick();
    end
    checks++; if (c8 !== 4'd4) begin errors++; $display("FAIL flush_pre_count: got %0d want 4", c8); end
    v8 = 1'b1; d8 = 8'h77; f8 = 1'b1;
    tick();
    v8 = 1'b0; f8 = 1'b0;
    checks++; if (c8 !== 4'd0)  begin errors++; $display("FAIL flush_count: got %0d want 0", c8); end
    checks++; if (vo8 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", vo8); end
    tick();
    checks++; if (c8 !== 4'd0)  begin errors++; $display("FAIL flush_word_lost: got %0d want 0", c8); end
    v8 = 1'b1; d8 = 8'h3C;
    tick();
    v8 = 1'b0;
    checks++; if (q8 !== 8'h3C || c8 !== 4'd1) begin
      errors++; $display("FAIL post_flush_push: data %h count %0d want 3c/1", q8, c8);
    end
    y8 = 1'b1;
    tick();
    y8 = 1'b0;
`ifdef FIFO_COUNTED_ERR_EN
    checks++; if (e8 !== 2'b00) begin errors++; $display("FAIL err_clear_start: got %b want 00", e8); end
    y8 = 1'b1;
    tick();
    y8 = 1'b0;
    checks++; if (e8 !== 2'b10) begin errors++; $display("FAIL err_underrun: got %b want 10", e8); end
    tick();
    checks++; if (e8 !== 2'b10) begin errors++; $display("FAIL err_sticky: got %b want 10", e8); end
    f8 = 1'b1;
    tick();
    f8 = 1'b0;
    checks++; if (e8 !== 2'b00) begin errors++; $display("FAIL err_flush_clear: got %b want 00", e8); end
`endif
    checks++; if (c8 !== 4'd0) begin errors++; $display("FAIL flush_end_count: got %0d want 0", c8); end
  endtask

  initial begin
    f5 = 1'b0; v5 = 1'b0; y5 = 1'b0; d5 = 8'h00;
    f8 = 1'b0; v8 = 1'b0; y8 = 1'b0; d8 = 8'h00;
    test_reset();
    test_fill_wrap();
    test_full_concurrency();
    test_empty_concurrency();
    test_flags();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
